branch_pc_unit: RTL and testbench

- Consumer end of the ALU-flags path. Holds the program counter and reads the 2-bit registered Flags from the flags register.
- Resolves conditional branches, calls and returns against those flags.
- Sits between instruction decode (requests, target address) and instruction fetch (Pc).
- Contains a small hardware return-address stack.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/branch_pc_unit_if.sv | 31 +++
 rtl/branch_pc_unit_stack.sv | 57 +++++
 rtl/branch_pc_unit.sv | 112 +++++++++++
 tb/tb_branch_pc_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, flag bit positions and the
// default program-counter width.
package cpu_pkg;

    localparam int ADDR_W = 8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_NZ     = 3'b010;
    localparam logic [2:0] COND_C      = 3'b011;
    localparam logic [2:0] COND_NC     = 3'b100;
    localparam logic [2:0] COND_NZ_NC  = 3'b101;
    localparam logic [2:0] COND_Z_OR_C = 3'b110;
    localparam logic [2:0] COND_NEVER  = 3'b111;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Decode/fetch side bundle of the branch/PC unit: requests in, PC and stack
// status out.
interface branch_pc_unit_if #(
    parameter int ADDR_W      = cpu_pkg::ADDR_W,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

    logic              PcEn;
    logic              BranchReq;
    logic [2:0]        BranchCond;
    logic              CallReq;
    logic              RetReq;
    logic [ADDR_W-1:0] TargetAddr;
    logic [1:0]        Flags;
    logic [ADDR_W-1:0] Pc;
    logic              Taken;
    logic              StackErr;
    logic [DEPTH_W-1:0] StackDepth;

    modport master (
        output PcEn, BranchReq, BranchCond, CallReq, RetReq, TargetAddr, Flags,
        input  Pc, Taken, StackErr, StackDepth
    );

    modport slave (
        input  PcEn, BranchReq, BranchCond, CallReq, RetReq, TargetAddr, Flags,
        output Pc, Taken, StackErr, StackDepth
    );

endinterface

// File: rtl/branch_pc_unit_stack.sv
// Return-address LIFO: registered storage, combinational view of the top
// entry, synchronous active-high reset of the occupancy count only.
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int DEPTH_W = $clog2(DEPTH) + 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [PTR_W-1:0]   wr_idx;
    logic [PTR_W-1:0]   top_idx;
    logic               do_push;
    logic               do_pop;

    assign full    = (depth_q == DEPTH_W'(DEPTH));
    assign empty   = (depth_q == '0);
    // Pop wins if both arrive together; the caller never asks for both.
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !pop;
    assign wr_idx  = PTR_W'(depth_q);
    assign top_idx = PTR_W'(depth_q - 1'b1);
    assign dout    = mem[top_idx];
    assign depth   = depth_q;

    // NOTE: non-blocking assignments for every flop so all registers update
    // from the same pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            depth_q <= '0;
        end else if (do_pop) begin
            depth_q <= depth_q - 1'b1;
        end else if (do_push) begin
            depth_q <= depth_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; entries above depth are never
    // read, so clearing them would only add reset fan-out.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter with conditional branch, call and return resolution against
// the registered ALU flags, backed by a small return-address stack.
module branch_pc_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = cpu_pkg::ADDR_W,
    parameter int STACK_DEPTH = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    branch_pc_unit_if.slave bus
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_W-1:0]  pc_q, pc_next, pc_inc;
    logic               taken_q, taken_next;
    logic               err_q, err_next;
    logic               push, pop;
    logic [ADDR_W-1:0]  stack_top;
    logic [DEPTH_W-1:0] stack_depth;
    logic               stack_full, stack_empty;

    function automatic logic cond_met(input logic [2:0] cond, input logic [1:0] flags);
        logic z;
        logic c;
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        case (cond)
            COND_ALWAYS: return 1'b1;
            COND_Z:      return z;
            COND_NZ:     return !z;
            COND_C:      return c;
            COND_NC:     return !c;
            COND_NZ_NC:  return !z && !c;
            COND_Z_OR_C: return z || c;
            default:     return 1'b0;
        endcase
    endfunction

    assign pc_inc = pc_q + ADDR_W'(1);

    // One action per cycle: return, then call, then branch, then advance.
    // NOTE: every output of this block gets a default first so no path can
    // infer a latch.
    always_comb begin
        pc_next    = pc_q;
        taken_next = 1'b0;
        err_next   = err_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (bus.RetReq) begin
            if (!stack_empty) begin
                pop        = 1'b1;
                pc_next    = stack_top;
                taken_next = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (bus.CallReq) begin
            if (!stack_full) begin
                push       = 1'b1;
                pc_next    = bus.TargetAddr;
                taken_next = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (bus.BranchReq) begin
            if (cond_met(bus.BranchCond, bus.Flags)) begin
                pc_next    = bus.TargetAddr;
                taken_next = 1'b1;
            end else begin
                pc_next = pc_inc;
            end
        end else if (bus.PcEn) begin
            pc_next = pc_inc;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q    <= '0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_next;
            taken_q <= taken_next;
            err_q   <= err_next;
        end
    end

    return_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stack_top),
        .depth (stack_depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    assign bus.Pc         = pc_q;
    assign bus.Taken      = taken_q;
    assign bus.StackErr   = err_q;
    assign bus.StackDepth = stack_depth;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: a vector table from reset, a condition
// sweep against a hand-written truth table, and stack/priority sequences.
module tb_branch_pc_unit;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    branch_pc_unit_if #(.ADDR_W(8), .STACK_DEPTH(4)) bus ();

    branch_pc_unit #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct {
        logic       pc_en;
        logic       br;
        logic [2:0] cond;
        logic       call;
        logic       ret;
        logic [7:0] target;
        logic [1:0] flags;
        logic [7:0] exp_pc;
        logic       exp_taken;
        logic [2:0] exp_depth;
        logic       exp_err;
    } vec_t;

    int errors = 0;
    int checks = 0;

    vec_t vecs [12];
    // Bit f of entry c: is cond c taken when Flags == f ({C,Z}).
    logic [3:0] cond_mask [8];

    function automatic vec_t mk(input logic pc_en, input logic br, input logic [2:0] cond,
                                input logic call, input logic ret, input logic [7:0] target,
                                input logic [1:0] flags, input logic [7:0] exp_pc,
                                input logic exp_taken, input logic [2:0] exp_depth,
                                input logic exp_err);
        vec_t v;
        v.pc_en = pc_en; v.br = br; v.cond = cond; v.call = call; v.ret = ret;
        v.target = target; v.flags = flags; v.exp_pc = exp_pc; v.exp_taken = exp_taken;
        v.exp_depth = exp_depth; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pc_en, input logic br, input logic [2:0] cond,
                         input logic call, input logic ret, input logic [7:0] target,
                         input logic [1:0] flags);
        bus.PcEn       = pc_en;
        bus.BranchReq  = br;
        bus.BranchCond = cond;
        bus.CallReq    = call;
        bus.RetReq     = ret;
        bus.TargetAddr = target;
        bus.Flags      = flags;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 2'b00);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] pc, input logic taken,
                               input logic [2:0] depth, input logic err);
        check({tag, ".pc"},    bus.Pc,         pc);
        check({tag, ".taken"}, bus.Taken,      taken);
        check({tag, ".depth"}, bus.StackDepth, depth);
        check({tag, ".err"},   bus.StackErr,   err);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        idle();
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        cond_mask[0] = 4'b1111;
        cond_mask[1] = 4'b1010;
        cond_mask[2] = 4'b0101;
        cond_mask[3] = 4'b1100;
        cond_mask[4] = 4'b0011;
        cond_mask[5] = 4'b0001;
        cond_mask[6] = 4'b1110;
        cond_mask[7] = 4'b0000;

        //              en    br    cond    call  ret   tgt    flg    pc     tk    dep     err
        vecs[0]  = mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 2'b00, 8'h01, 1'b0, 3'd0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 2'b00, 8'h02, 1'b0, 3'd0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 2'b00, 8'h03, 1'b0, 3'd0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 2'b00, 8'h03, 1'b0, 3'd0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 8'h40, 2'b01, 8'h40, 1'b1, 3'd0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 8'h77, 2'b01, 8'h41, 1'b0, 3'd0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 8'h10, 2'b00, 8'h10, 1'b1, 3'd0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'h20, 2'b00, 8'h20, 1'b1, 3'd1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'h30, 2'b00, 8'h30, 1'b1, 3'd2, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 8'h00, 2'b00, 8'h21, 1'b1, 3'd1, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 8'h00, 2'b00, 8'h11, 1'b1, 3'd0, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 8'h00, 2'b00, 8'h11, 1'b0, 3'd0, 1'b1);

        Rst = 1'b1;
        idle();
        tick();
        tick();
        check_state("reset", 8'h00, 1'b0, 3'd0, 1'b0);
        Rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].pc_en, vecs[i].br, vecs[i].cond, vecs[i].call, vecs[i].ret,
                  vecs[i].target, vecs[i].flags);
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_taken,
                        vecs[i].exp_depth, vecs[i].exp_err);
        end

        // Condition sweep: park Pc at 0x10, then branch to 0x80.
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 4; f++) begin
                logic exp_t;
                exp_t = cond_mask[c][f];
                drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 8'h10, 2'b00);
                tick();
                drive(1'b0, 1'b1, 3'(c), 1'b0, 1'b0, 8'h80, 2'(f));
                tick();
                check($sformatf("sweep_c%0d_f%0d.pc", c, f), bus.Pc, exp_t ? 8'h80 : 8'h11);
                check($sformatf("sweep_c%0d_f%0d.taken", c, f), bus.Taken, exp_t);
            end
        end

        // Pc wrap at 0xFF, Taken lasts one cycle.
        do_reset();
        drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 8'hFF, 2'b00);
        tick();
        check_state("wrap_load", 8'hFF, 1'b1, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 2'b00);
        tick();
        check_state("wrap_inc", 8'h00, 1'b0, 3'd0, 1'b0);
        idle();
        tick();
        check_state("wrap_hold", 8'h00, 1'b0, 3'd0, 1'b0);

        // Fill the stack, overflow, then unwind LIFO.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'hA0 + 8'(i), 2'b00);
            tick();
            check_state($sformatf("fill%0d", i), 8'hA0 + 8'(i), 1'b1, 3'(i + 1), 1'b0);
        end
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'hB0, 2'b00);
        tick();
        check_state("overflow", 8'hA3, 1'b0, 3'd4, 1'b1);
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 8'h00, 2'b00);
        tick();
        check_state("unwind0", 8'hA3, 1'b1, 3'd3, 1'b1);
        tick();
        check_state("unwind1", 8'hA2, 1'b1, 3'd2, 1'b1);
        tick();
        check_state("unwind2", 8'hA1, 1'b1, 3'd1, 1'b1);
        tick();
        check_state("unwind3", 8'h01, 1'b1, 3'd0, 1'b1);

        // Return on an empty stack straight out of reset.
        do_reset();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 8'h00, 2'b00);
        tick();
        check_state("underflow", 8'h00, 1'b0, 3'd0, 1'b1);

        // Priority: return beats call, branch and advance; call beats branch.
        do_reset();
        drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 8'h54, 2'b00);
        tick();
        check_state("prio_setup", 8'h54, 1'b1, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'h90, 2'b00);
        tick();
        check_state("prio_call", 8'h90, 1'b1, 3'd1, 1'b0);
        drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 8'h90, 2'b00);
        tick();
        check_state("prio_ret", 8'h55, 1'b1, 3'd0, 1'b0);
        drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 8'h66, 2'b00);
        tick();
        check_state("prio_call_br", 8'h66, 1'b1, 3'd1, 1'b0);
        drive(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 8'h22, 2'b11);
        tick();
        check_state("prio_br_never", 8'h67, 1'b0, 3'd1, 1'b0);

        // Reset overrides a same-cycle call.
        Rst = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'h99, 2'b00);
        tick();
        check_state("rst_call", 8'h00, 1'b0, 3'd0, 1'b0);
        Rst = 1'b0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
